// File: rtl/exu_mc_pkg.sv
// Shared opcodes, operand-select codes, FSM states and width defaults for exu_mc.
package exu_mc_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int SEL_W_DEF = 3;
   localparam int OPT_W_DEF = 5;

   localparam logic [2:0] SEL_REG = 3'd0;
   localparam logic [2:0] SEL_IMM = 3'd1;
   localparam logic [2:0] SEL_PC4 = 3'd2;
   localparam logic [2:0] SEL_PCI = 3'd3;
   localparam logic [2:0] SEL_CSR = 3'd4;

   localparam logic [4:0] OP_ADD    = 5'd0;
   localparam logic [4:0] OP_SUB    = 5'd1;
   localparam logic [4:0] OP_SLL    = 5'd2;
   localparam logic [4:0] OP_SLT    = 5'd3;
   localparam logic [4:0] OP_SLTU   = 5'd4;
   localparam logic [4:0] OP_XOR    = 5'd5;
   localparam logic [4:0] OP_SRL    = 5'd6;
   localparam logic [4:0] OP_SRA    = 5'd7;
   localparam logic [4:0] OP_OR     = 5'd8;
   localparam logic [4:0] OP_AND    = 5'd9;
   localparam logic [4:0] OP_BEQ    = 5'd10;
   localparam logic [4:0] OP_BNE    = 5'd11;
   localparam logic [4:0] OP_BLT    = 5'd12;
   localparam logic [4:0] OP_BGE    = 5'd13;
   localparam logic [4:0] OP_BLTU   = 5'd14;
   localparam logic [4:0] OP_BGEU   = 5'd15;
   localparam logic [4:0] OP_MUL    = 5'd16;
   localparam logic [4:0] OP_MULH   = 5'd17;
   localparam logic [4:0] OP_MULHSU = 5'd18;
   localparam logic [4:0] OP_MULHU  = 5'd19;
   localparam logic [4:0] OP_DIV    = 5'd20;
   localparam logic [4:0] OP_DIVU   = 5'd21;
   localparam logic [4:0] OP_REM    = 5'd22;
   localparam logic [4:0] OP_REMU   = 5'd23;
   localparam logic [4:0] OP_UNK    = 5'd31;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } exu_state_t;

   // Mul/div opcodes occupy 16..23; the low three bits select the variant.
   function automatic logic is_mdu_op(input logic [4:0] opt);
      return opt[4:3] == 2'b10;
   endfunction

endpackage

// File: rtl/exu_mdu.sv
// Iterative multiply/divide engine: one result bit per cycle, XLEN iterations after i_start.
module exu_mdu #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   input  logic            i_abort,
   input  logic [2:0]      i_op,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic            o_done,
   output logic [XLEN-1:0] o_res
);
   localparam int CNT_W = $clog2(XLEN);

   logic              r_busy;
   logic [CNT_W-1:0]  r_cnt;
   logic [XLEN-1:0]   r_hi, r_lo, r_b;
   logic [2:0]        r_op;
   logic              r_neg_q, r_neg_r;

   logic              w_a_sgn, w_b_sgn, w_a_neg, w_b_neg, w_ge;
   logic [XLEN-1:0]   w_a_mag, w_b_mag, w_hi_next, w_lo_next;
   logic [XLEN:0]     w_add, w_shl;
   logic [2*XLEN-1:0] w_prod, w_prod_s;

   // Operands are processed as magnitudes; signs are re-applied on the final result.
   assign w_a_sgn = i_op[2] ? ~i_op[0] : (i_op[1:0] == 2'b01 || i_op[1:0] == 2'b10);
   assign w_b_sgn = i_op[2] ? ~i_op[0] : (i_op[1:0] == 2'b01);
   assign w_a_neg = w_a_sgn & i_a[XLEN-1];
   assign w_b_neg = w_b_sgn & i_b[XLEN-1];
   assign w_a_mag = w_a_neg ? -i_a : i_a;
   assign w_b_mag = w_b_neg ? -i_b : i_b;

   assign w_add = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
   assign w_shl = {r_hi, r_lo[XLEN-1]};
   assign w_ge  = w_shl >= {1'b0, r_b};

   always_comb begin
      if (r_op[2]) begin
         w_hi_next = w_ge ? XLEN'(w_shl - {1'b0, r_b}) : w_shl[XLEN-1:0];
         w_lo_next = {r_lo[XLEN-2:0], w_ge};
      end else begin
         w_hi_next = w_add[XLEN:1];
         w_lo_next = {w_add[0], r_lo[XLEN-1:1]};
      end
   end

   // The result is taken from the last iteration's next-state so it lands with o_done.
   assign w_prod   = {w_hi_next, w_lo_next};
   assign w_prod_s = r_neg_q ? -w_prod : w_prod;

   always_comb begin
      if (!r_op[2])
         o_res = (r_op[1:0] == 2'b00) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];
      else if (!r_op[1])
         o_res = r_neg_q ? -w_lo_next : w_lo_next;
      else
         o_res = r_neg_r ? -w_hi_next : w_hi_next;
   end

   assign o_done = r_busy & (r_cnt == CNT_W'(XLEN-1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_busy  <= 1'b0;
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_b     <= '0;
         r_op    <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (i_abort) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
      end else if (i_start) begin
         r_busy  <= 1'b1;
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= w_a_mag;
         r_b     <= w_b_mag;
         r_op    <= i_op;
         // Division by zero keeps an all-ones quotient and the dividend as remainder.
         r_neg_q <= (w_a_neg ^ w_b_neg) & (~i_op[2] | (i_b != '0));
         r_neg_r <= w_a_neg;
      end else if (r_busy) begin
         r_hi  <= w_hi_next;
         r_lo  <= w_lo_next;
         r_cnt <= r_cnt + 1'b1;
         if (o_done) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
         end
      end
   end

endmodule

// File: rtl/exu_mc.sv
// Execution unit: operand mux, single-cycle ALU and optional iterative mul/div behind a valid/ready FSM.
// Mul/div support is built only when the EXU_MDU_EN macro is defined.
module exu_mc
   import exu_mc_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int SEL_W = SEL_W_DEF,
   parameter int OPT_W = OPT_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [XLEN-1:0]  i_pc,
   input  logic [XLEN-1:0]  i_rs1,
   input  logic [XLEN-1:0]  i_rs2,
   input  logic [XLEN-1:0]  i_imm,
   input  logic [XLEN-1:0]  i_csr,
   input  logic [SEL_W-1:0] i_src_sel,
   input  logic [OPT_W-1:0] i_opt,
   input  logic             i_flush,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [XLEN-1:0]  o_exu_res,
   output logic             o_zero,
   output logic             o_busy
);
   localparam int SH_W = $clog2(XLEN);

   exu_state_t      r_state, w_state_next;
   logic [XLEN-1:0] r_res, w_res_next;
   logic [XLEN-1:0] w_a, w_b, w_alu_res, w_mdu_res;
   logic [XLEN:0]   w_sub_s, w_sub_u;
   logic [SH_W-1:0] w_sh;
   logic [4:0]      w_opt;
   logic [2:0]      w_sel;
   logic            w_lt, w_ltu, w_eq, w_accept, w_md_op, w_mdu_done;

   // Codes outside the 5-bit/3-bit spaces fall to the add and (0,csr) defaults.
   assign w_opt = ((i_opt >> 5) == '0) ? i_opt[4:0] : OP_UNK;
   assign w_sel = ((i_src_sel >> 3) == '0) ? i_src_sel[2:0] : SEL_CSR;

   always_comb begin
      w_a = '0;
      w_b = i_csr;
      case (w_sel)
         SEL_REG: begin w_a = i_rs1; w_b = i_rs2; end
         SEL_IMM: begin w_a = i_rs1; w_b = i_imm; end
         SEL_PC4: begin w_a = i_pc;  w_b = XLEN'(4); end
         SEL_PCI: begin w_a = i_pc;  w_b = i_imm; end
         default: ;
      endcase
   end

   assign w_sub_s = {w_a[XLEN-1], w_a} - {w_b[XLEN-1], w_b};
   assign w_sub_u = {1'b0, w_a} - {1'b0, w_b};
   assign w_lt    = w_sub_s[XLEN];
   assign w_ltu   = w_sub_u[XLEN];
   assign w_eq    = (w_a == w_b);
   assign w_sh    = w_b[SH_W-1:0];

   always_comb begin
      w_alu_res = w_a + w_b;
      case (w_opt)
         OP_SUB:  w_alu_res = w_a - w_b;
         OP_SLL:  w_alu_res = w_a << w_sh;
         OP_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, w_lt};
         OP_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, w_ltu};
         OP_XOR:  w_alu_res = w_a ^ w_b;
         OP_SRL:  w_alu_res = w_a >> w_sh;
         OP_SRA:  w_alu_res = $unsigned($signed(w_a) >>> w_sh);
         OP_OR:   w_alu_res = w_a | w_b;
         OP_AND:  w_alu_res = w_a & w_b;
         OP_BEQ:  w_alu_res = {{(XLEN-1){1'b0}}, w_eq};
         OP_BNE:  w_alu_res = {{(XLEN-1){1'b0}}, ~w_eq};
         OP_BLT:  w_alu_res = {{(XLEN-1){1'b0}}, w_lt};
         OP_BGE:  w_alu_res = {{(XLEN-1){1'b0}}, ~w_lt};
         OP_BLTU: w_alu_res = {{(XLEN-1){1'b0}}, w_ltu};
         OP_BGEU: w_alu_res = {{(XLEN-1){1'b0}}, ~w_ltu};
         OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
         OP_DIV, OP_DIVU, OP_REM, OP_REMU: w_alu_res = '0;
         default: ;
      endcase
   end

   assign o_ready  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & i_ready);
   assign w_accept = i_valid & o_ready & ~i_flush;

`ifdef EXU_MDU_EN
   assign w_md_op = is_mdu_op(w_opt);
   assign o_busy  = (r_state == ST_CALC);

   exu_mdu #(.XLEN(XLEN)) u_mdu (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_start (w_accept & w_md_op),
      .i_abort (i_flush),
      .i_op    (w_opt[2:0]),
      .i_a     (w_a),
      .i_b     (w_b),
      .o_done  (w_mdu_done),
      .o_res   (w_mdu_res)
   );
`else
   assign w_md_op    = 1'b0;
   assign o_busy     = 1'b0;
   assign w_mdu_done = 1'b0;
   assign w_mdu_res  = '0;
`endif

   always_comb begin
      w_state_next = r_state;
      w_res_next   = r_res;
      if (w_accept) begin
         w_state_next = w_md_op ? ST_CALC : ST_DONE;
         if (!w_md_op)
            w_res_next = w_alu_res;
      end else if (r_state == ST_DONE && i_ready) begin
         w_state_next = ST_IDLE;
      end else if (r_state == ST_CALC && w_mdu_done) begin
         w_state_next = ST_DONE;
         w_res_next   = w_mdu_res;
      end
      if (i_flush) begin
         w_state_next = ST_IDLE;
         w_res_next   = r_res;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_res   <= '0;
      end else begin
         r_state <= w_state_next;
         r_res   <= w_res_next;
      end
   end

   assign o_valid   = (r_state == ST_DONE);
   assign o_exu_res = r_res;
   assign o_zero    = (r_res == '0);

endmodule

// File: doc/exu_mc.md
EXU_MC -- requirements
Module: exu_mc

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter SEL_W, default 3, operand-select code width.
REQ-003 Parameter OPT_W, default 5, operation code width.
REQ-004 i_clk  in  1  single clock; all state changes on rising edge.
REQ-005 i_rst  in  1  reset, asynchronous, active-high.
REQ-006 i_valid  in  1  upstream operation valid.
REQ-007 o_ready  out  1  block can accept an operation this cycle.
REQ-008 i_pc, i_rs1, i_rs2, i_imm, i_csr  in  XLEN each  operand sources.
REQ-009 i_src_sel  in  SEL_W  operand-pair select: REG, IMM, PC4, PCI, CSR.
REQ-010 i_opt  in  OPT_W  operation: ALU ops, SLT/SLTU, BEQ/BNE/BLT/BGE/BLTU/BGEU, MUL/MULH/MULHSU/MULHU, DIV/DIVU/REM/REMU.
REQ-011 i_flush  in  1  abort in-flight operation.
REQ-012 o_valid  out  1  registered result valid.
REQ-013 i_ready  in  1  downstream accepts result.
REQ-014 o_exu_res  out  XLEN  registered result.
REQ-015 o_zero  out  1  high when o_exu_res is all zeros.
REQ-016 o_busy  out  1  high while a multi-cycle op is in CALC.

Function
REQ-017 Operand mux: REG->(rs1,rs2), IMM->(rs1,imm), PC4->(pc,4), PCI->(pc,imm), CSR and unused codes->(0,csr).
REQ-018 Handshake: operation accepted on cycle where i_valid & o_ready; result held stable while o_valid & ~i_ready.
REQ-019 FSM states IDLE, CALC, DONE; IDLE->DONE for single-cycle ops, IDLE->CALC for mul/div, CALC->DONE at iteration end, DONE->IDLE on i_ready without new accept.
REQ-020 o_ready = (state==IDLE) | (state==DONE & i_ready); accept in DONE with i_ready gives back-to-back throughput for single-cycle ops.
REQ-021 Single-cycle ops: o_valid asserted the cycle after acceptance (latency 1).
REQ-022 Compare/branch results: bit 0 = condition, bits XLEN-1:1 = 0.
REQ-023 Signed less-than computed via (XLEN+1)-bit sign-extended subtraction; unsigned via zero-extended; correct for all operand pairs including most-negative value.
REQ-024 Mul/div: one bit per cycle; o_valid asserted exactly XLEN+1 cycles after acceptance.
REQ-025 MULH/MULHSU/MULHU return upper XLEN bits of 2*XLEN product with rs1/rs2 signedness s/s, s/u, u/u; MUL returns lower XLEN bits.
REQ-026 Divide by zero: DIV/DIVU -> all ones; REM/REMU -> dividend.
REQ-027 Signed overflow (most-negative / -1): DIV -> most-negative, REM -> 0.
REQ-028 i_flush: any state -> IDLE next cycle, o_valid deasserted, no result delivered; i_flush with i_valid same cycle: operation not accepted.
REQ-029 Unknown i_opt: result = ALU default path with add semantics, latency 1.

Reset
REQ-030 On i_rst: state IDLE, o_valid 0, o_busy 0, o_exu_res 0, o_zero 1, iteration counter 0; reset mid-CALC discards the operation.

Configuration
REQ-031 Macro EXU_MDU_EN defined: mul/div ops implemented per REQ-024..027.
REQ-032 EXU_MDU_EN undefined: mul/div sub-module absent, CALC unreachable, o_busy tied 0, mul/div opcodes return 0 with latency 1.

Structure
REQ-033 Opcode, select codes, state encodings, XLEN default reside in the shared defines file.
REQ-034 Iterative multiply/divide engine is one sub-module, exu_mdu, with start/done handshake; combinational ALU reused unchanged.

Verification (XLEN=32)
REQ-035 ADD REG rs1=5, rs2=7 -> o_valid one cycle later, o_exu_res=12, o_zero=0.
REQ-036 SLT rs1=0x80000000, rs2=1 -> 1; SLTU same operands -> 0; BGE rs1=rs2=3 -> 1.
REQ-037 MULHU rs1=rs2=0xFFFFFFFF -> 0xFFFFFFFE after 33 cycles, o_busy high cycles 1..32.
REQ-038 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
REQ-039 i_ready held low 4 cycles after result -> o_exu_res and o_valid stable; then back-to-back ADDs yield one result per cycle.
REQ-040 i_flush at cycle 10 of DIV, and separately i_rst mid-CALC -> IDLE next cycle, no o_valid, o_ready high.
